mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles without mem_ack before abort (legal range 2..255).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port if_req, input, 1, instruction-fetch request, held until if_done.
REQ-007 SHALL have port if_addr, input, MEM_ADDR_WIDTH, fetch address.
REQ-008 SHALL have port if_rdata, output, WORD_WIDTH, registered fetch read data.
REQ-009 SHALL have port if_done, output, 1, one-cycle fetch-completion pulse.
REQ-010 SHALL have port d_req, input, 1, data request, held until d_done.
REQ-011 SHALL have port d_wr, input, 1, 1 = store, 0 = load.
REQ-012 SHALL have ports d_addr and d_wdata, input, MEM_ADDR_WIDTH and WORD_WIDTH, data address and store data.
REQ-013 SHALL have port d_rdata, output, WORD_WIDTH, registered load data.
REQ-014 SHALL have port d_done, output, 1, one-cycle data-completion pulse.
REQ-015 SHALL have port err, output, 1, pulses together with if_done or d_done when the transaction timed out.
REQ-016 SHALL have ports mem_req, mem_wr, mem_addr, mem_wdata, output, 1/1/MEM_ADDR_WIDTH/WORD_WIDTH, registered shared-memory command.
REQ-017 SHALL have ports mem_rdata (input, WORD_WIDTH) and mem_ack (input, 1), memory response; mem_rdata is valid in the cycle mem_ack is high.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_IF and BUSY_D.
REQ-019 In IDLE, SHALL select a requester: if only one of if_req/d_req is high, select it; if both are high, select the one not served last (round-robin pointer last_d).
REQ-020 On selection, SHALL on the next edge latch address/wr/wdata into mem_* outputs, assert mem_req, update last_d and enter BUSY_IF or BUSY_D.
REQ-021 Fetch commands SHALL drive mem_wr=0 and mem_wdata=0.
REQ-022 Latency: request high at cycle N (in IDLE) gives mem_req high at N+1; mem_ack at cycle M gives done pulse at M+1.
REQ-023 While BUSY, mem_req, mem_wr, mem_addr and mem_wdata SHALL hold stable until mem_ack is sampled high.
REQ-024 On mem_ack in BUSY_IF, SHALL register mem_rdata into if_rdata, pulse if_done, drop mem_req and return to IDLE.
REQ-025 On mem_ack in BUSY_D, SHALL pulse d_done and drop mem_req; d_rdata SHALL be updated only for loads and left unchanged for stores.
REQ-026 The done-pulse cycle SHALL be spent in IDLE with no new grant; arbitration resumes on the following cycle, so a held req is never served twice.
REQ-027 mem_ack while in IDLE SHALL be ignored.
REQ-028 Deassertion of the active req mid-transaction SHALL NOT abort it; done still pulses.
REQ-029 A request arriving for the other requester while BUSY SHALL wait and be granted at the next arbitration.
REQ-030 An 8-bit cycle counter SHALL count BUSY cycles without ack. On reaching TIMEOUT, SHALL drop mem_req, pulse done for the active requester with err=1, leave rdata unchanged and return to IDLE.
REQ-031 The counter SHALL clear on every grant.
REQ-032 mem_ack in the same cycle as the timeout SHALL take precedence: normal completion, err=0.

Reset
REQ-033 nrst low SHALL asynchronously force state=IDLE, counter=0 and last_d=0, so data wins the first tie.
REQ-034 nrst low SHALL asynchronously force mem_req, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done and err to 0.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no done pulse.
REQ-036 Operation SHALL resume on the first edge after nrst rises.

Verification
REQ-037 Single fetch: if_req=1, if_addr=0x40 at N; mem_ack=1, mem_rdata=0x2402000A at N+3 -> mem_req high N+1..N+3, mem_addr=0x40, if_done=1 and if_rdata=0x2402000A at N+4.
REQ-038 Tie after reset: if_req=d_req=1 -> data served first, then fetch; with both held, grants alternate D, IF, D, IF.
REQ-039 Store: d_req=1, d_wr=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_wr=1 with that addr/data; d_done pulses after ack; d_rdata keeps its prior value.
REQ-040 Timeout: fetch granted, mem_ack never asserted -> mem_req drops and if_done=1 with err=1 at TIMEOUT(16) BUSY cycles; next request is granted normally.
REQ-041 Reset mid-op: nrst=0 during BUSY_D -> all outputs 0 immediately, no d_done pulse; after release, a held d_req is re-granted.
REQ-042 Ack/timeout collision: mem_ack arrives in the 16th BUSY cycle -> normal done pulse, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one shared memory, round-robin on ties, with ack timeout.
// Latency: grant 1 cycle after request in IDLE; done pulse 1 cycle after mem_ack or timeout.
// Backpressure: requesters hold req until their done pulse; memory stalls by withholding mem_ack.
module mem_arbiter #(
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      nrst,
  // instruction-fetch port
  input  logic                      if_req,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0]     if_rdata,
  output logic                      if_done,
  // data port
  input  logic                      d_req,
  input  logic                      d_wr,
  input  logic [MEM_ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0]     d_wdata,
  output logic [WORD_WIDTH-1:0]     d_rdata,
  output logic                      d_done,
  output logic                      err,
  // shared memory
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  // Counter value seen in the last BUSY cycle allowed before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       last_d;
  logic       grant_if;
  logic       grant_d;
  logic       busy;
  logic       timeout;
  logic       finish;

  // Next-state logic: arbitration in IDLE, completion/timeout detection in BUSY.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    busy      = (state != IDLE);
    // ack wins over timeout when both land in the same cycle
    timeout   = busy && !mem_ack && (wait_cnt == CNT_LAST);
    finish    = busy && (mem_ack || timeout);
    case (state)
      IDLE: begin
        // a done pulse still on the outputs means the requester has not yet
        // had a chance to drop its req, so skip arbitration this cycle
        if (!if_done && !d_done) begin
          if (d_req && (!if_req || !last_d)) begin
            grant_d   = 1'b1;
            state_nxt = BUSY_D;
          end else if (if_req) begin
            grant_if  = 1'b1;
            state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin pointer and BUSY wait counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_d   <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      if (grant_d || grant_if) begin
        last_d   <= grant_d;
        wait_cnt <= 8'd0;
      end else if (finish) begin
        wait_cnt <= 8'd0;
      end else if (busy) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Registered memory command, read data and completion pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_wr    <= d_wr;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_wr    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (finish) begin
        mem_req <= 1'b0;
        err     <= timeout;
        if (state == BUSY_IF) begin
          if_done <= 1'b1;
          if (mem_ack) begin
            if_rdata <= mem_rdata;
          end
        end else begin
          d_done <= 1'b1;
          // stores leave the load-data register alone
          if (mem_ack && !mem_wr) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations at hand-picked cycles.
// Inputs change 1 time unit after the rising edge; model outputs compared on the falling edge.
module tb_mem_arbiter;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [WW-1:0] if_rdata;
  logic          if_done;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [WW-1:0] d_wdata = '0;
  logic [WW-1:0] d_rdata;
  logic          d_done;
  logic          err;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  mem_arbiter #(.WORD_WIDTH(WW), .MEM_ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_active = 0;   // a memory transaction is outstanding
  bit          m_is_d = 0;     // outstanding transaction belongs to the data port
  bit          m_wr = 0;
  bit          m_last_d = 0;   // data port was the most recent one served
  bit          m_cool = 0;     // a done pulse is showing this cycle
  int          m_age = 0;      // BUSY cycles elapsed for the outstanding transaction
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  bit          m_if_done = 0;
  bit          m_d_done = 0;
  bit          m_err = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active = 0; m_is_d = 0; m_wr = 0; m_last_d = 0; m_cool = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
      m_if_done = 0; m_d_done = 0; m_err = 0;
    end else begin
      m_if_done = 0;
      m_d_done  = 0;
      m_err     = 0;
      if (m_active) begin
        if (mem_ack) begin
          if (m_is_d) begin
            m_d_done = 1;
            if (!m_wr) m_d_rdata = mem_rdata;
          end else begin
            m_if_done  = 1;
            m_if_rdata = mem_rdata;
          end
          m_active = 0;
        end else if (m_age == TMO) begin
          if (m_is_d) m_d_done = 1;
          else        m_if_done = 1;
          m_err    = 1;
          m_active = 0;
        end else begin
          m_age++;
        end
      end else if (!m_cool && (if_req || d_req)) begin
        m_is_d   = d_req && (!if_req || !m_last_d);
        m_last_d = m_is_d;
        m_active = 1;
        m_age    = 1;
        m_addr   = m_is_d ? d_addr : if_addr;
        m_wr     = m_is_d ? d_wr : 1'b0;
        m_wdata  = m_is_d ? d_wdata : 32'h0;
      end
      m_cool = m_if_done || m_d_done;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_mem_req", {31'b0, mem_req}, {31'b0, m_active});
      if (m_active) begin
        chk("mdl_mem_wr", {31'b0, mem_wr}, {31'b0, m_wr});
        chk("mdl_mem_addr", mem_addr, m_addr);
        chk("mdl_mem_wdata", mem_wdata, m_wdata);
      end
      chk("mdl_if_done", {31'b0, if_done}, {31'b0, m_if_done});
      chk("mdl_d_done", {31'b0, d_done}, {31'b0, m_d_done});
      chk("mdl_err", {31'b0, err}, {31'b0, m_err});
      chk("mdl_if_rdata", if_rdata, m_if_rdata);
      chk("mdl_d_rdata", d_rdata, m_d_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] tie_addr [4];
  logic [31:0] tie_data [4];
  bit          tie_is_d [4];

  initial begin
    tie_addr = '{32'h200, 32'h80, 32'h200, 32'h80};
    tie_data = '{32'hA0000001, 32'hB0000002, 32'hA0000003, 32'hB0000004};
    tie_is_d = '{1'b1, 1'b0, 1'b1, 1'b0};

    // reset state
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    nrst = 1'b1;

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("idle_ack_if_done", {31'b0, if_done}, 32'd0);
    chk("idle_ack_if_rdata", if_rdata, 32'd0);
    mem_ack = 1'b0; mem_rdata = '0;

    // single fetch: req at N, ack at N+3, done at N+4
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("fetch_req_n1", {31'b0, mem_req}, 32'd1);
    chk("fetch_addr", mem_addr, 32'h40);
    chk("fetch_wr", {31'b0, mem_wr}, 32'd0);
    chk("fetch_wdata", mem_wdata, 32'd0);
    tick();
    tick();
    chk("fetch_req_n3", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2402000A;
    tick();
    chk("fetch_done", {31'b0, if_done}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h2402000A);
    chk("fetch_req_drop", {31'b0, mem_req}, 32'd0);
    chk("fetch_err", {31'b0, err}, 32'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
    chk("fetch_done_pulse", {31'b0, if_done}, 32'd0);

    // tie after reset: D, IF, D, IF
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_grant_req", {31'b0, mem_req}, 32'd1);
      chk("tie_grant_addr", mem_addr, tie_addr[i]);
      mem_ack = 1'b1; mem_rdata = tie_data[i];
      tick();
      mem_ack = 1'b0;
      chk("tie_d_done", {31'b0, d_done}, {31'b0, tie_is_d[i]});
      chk("tie_if_done", {31'b0, if_done}, {31'b0, !tie_is_d[i]});
      if (i == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      tick();
      chk("tie_done_cycle_idle", {31'b0, mem_req}, 32'd0);
    end
    chk("tie_final_d_rdata", d_rdata, 32'hA0000003);
    chk("tie_final_if_rdata", if_rdata, 32'hB0000004);

    // store; req dropped mid-transaction still completes
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    chk("store_wr", {31'b0, mem_wr}, 32'd1);
    chk("store_addr", mem_addr, 32'h100);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    d_req = 1'b0;
    tick();
    chk("store_hold_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("store_done", {31'b0, d_done}, 32'd1);
    chk("store_rdata_kept", d_rdata, 32'hA0000003);
    mem_ack = 1'b0; mem_rdata = '0; d_wr = 1'b0;
    tick();

    // timeout on fetch
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    chk("tmo_grant", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      chk("tmo_busy_req", {31'b0, mem_req}, 32'd1);
    end
    tick();
    chk("tmo_req_drop", {31'b0, mem_req}, 32'd0);
    chk("tmo_if_done", {31'b0, if_done}, 32'd1);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_rdata_kept", if_rdata, 32'hB0000004);
    if_req = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300;
    tick();
    chk("tmo_err_pulse", {31'b0, err}, 32'd0);
    chk("tmo_done_cycle_idle", {31'b0, mem_req}, 32'd0);
    tick();
    chk("post_tmo_grant", {31'b0, mem_req}, 32'd1);
    chk("post_tmo_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("post_tmo_done", {31'b0, d_done}, 32'd1);
    chk("post_tmo_err", {31'b0, err}, 32'd0);
    chk("post_tmo_rdata", d_rdata, 32'hCAFEF00D);
    mem_ack = 1'b0; d_req = 1'b0;
    tick();

    // ack in the last allowed BUSY cycle wins over timeout
    if_req = 1'b1; if_addr = 32'h48;
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
    end
    chk("coll_busy_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    chk("coll_done", {31'b0, if_done}, 32'd1);
    chk("coll_err", {31'b0, err}, 32'd0);
    chk("coll_rdata", if_rdata, 32'h55AA55AA);
    mem_ack = 1'b0; if_req = 1'b0;
    tick();

    // reset mid data transaction
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h400;
    tick();
    chk("rmid_grant", {31'b0, mem_req}, 32'd1);
    tick();
    nrst = 1'b0;
    #1;
    chk("rmid_req", {31'b0, mem_req}, 32'd0);
    chk("rmid_addr", mem_addr, 32'd0);
    chk("rmid_d_rdata", d_rdata, 32'd0);
    chk("rmid_if_rdata", if_rdata, 32'd0);
    tick();
    chk("rmid_no_done", {31'b0, d_done}, 32'd0);
    nrst = 1'b1;
    tick();
    chk("rmid_regrant", {31'b0, mem_req}, 32'd1);
    chk("rmid_regrant_addr", mem_addr, 32'h400);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    chk("rmid_done", {31'b0, d_done}, 32'd1);
    chk("rmid_rdata", d_rdata, 32'h0BADF00D);
    mem_ack = 1'b0; d_req = 1'b0;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
